// File: rtl/ex_mem_skid.sv
// EX->MEM elastic pipeline register: two-entry skid buffer with a
// registered in_ready and a forwarding tap on the youngest held beat.
module ex_mem_skid #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic [DATA_W-1:0] in_store_data,
    input  logic [REG_W-1:0]  in_rd_addr,
    input  logic              in_rd_we,
    input  logic              in_t_we,
    input  logic              in_t_val,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [DATA_W-1:0] out_store_data,
    output logic [REG_W-1:0]  out_rd_addr,
    output logic              out_rd_we,
    output logic              out_t_we,
    output logic              out_t_val,
    output logic              fwd_valid,
    output logic [REG_W-1:0]  fwd_rd_addr,
    output logic [DATA_W-1:0] fwd_data
);

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [DATA_W-1:0] store_data;
        logic [REG_W-1:0]  rd_addr;
        logic              rd_we;
        logic              t_we;
        logic              t_val;
    } beat_t;

    // Encoding is {main_valid, skid_valid}.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b10,
        FULL  = 2'b11
    } state_e;

    state_e state_q;
    state_e state_d;

    beat_t main_q;
    beat_t main_d;
    beat_t skid_q;
    beat_t skid_d;
    beat_t in_beat;

    logic main_valid;
    logic skid_valid;
    logic accept;
    logic deliver;
    logic ld_main_in;
    logic ld_main_skid;
    logic ld_skid;
    logic clear;

    assign main_valid = state_q[1];
    assign skid_valid = state_q[0];

    assign in_beat = '{
        result:     in_result,
        store_data: in_store_data,
        rd_addr:    in_rd_addr,
        rd_we:      in_rd_we,
        t_we:       in_t_we,
        t_val:      in_t_val
    };

    assign accept  = in_valid && in_ready;
    assign deliver = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept)
                        state_d = BUSY;
                end
                BUSY: begin
                    if (accept && !deliver)
                        state_d = FULL;
                    else if (!accept && deliver)
                        state_d = EMPTY;
                end
                FULL: begin
                    if (deliver)
                        state_d = BUSY;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_comb begin
        in_ready  = !skid_valid;
        out_valid = main_valid;
    end

    // Load strobes are mutually exclusive by state, and flush gates them all.
    assign clear = flush;

    assign ld_main_in = !flush && accept &&
        (state_q == EMPTY ||
         (state_q == BUSY && deliver));

    assign ld_main_skid = !flush && deliver &&
        state_q == FULL;

    assign ld_skid = !flush && accept &&
        !deliver && state_q == BUSY;

    always_comb begin
        main_d = main_q;
        skid_d = skid_q;
        unique case (1'b1)
            clear: begin
                main_d = '0;
                skid_d = '0;
            end
            ld_main_in: main_d = in_beat;
            ld_main_skid: begin
                main_d = skid_q;
                skid_d = '0;
            end
            ld_skid: skid_d = in_beat;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            main_q <= main_d;
            skid_q <= skid_d;
        end
    end

    assign out_result     = main_q.result;
    assign out_store_data = main_q.store_data;
    assign out_rd_addr    = main_q.rd_addr;
    assign out_rd_we      = main_q.rd_we;
    assign out_t_we       = main_q.t_we;
    assign out_t_val      = main_q.t_val;

    // The skid entry is always younger than main, so it wins.
    beat_t fwd_src;
    logic  fwd_src_valid;

    always_comb begin
        fwd_src       = skid_valid ? skid_q : main_q;
        fwd_src_valid = skid_valid || main_valid;
    end

    assign fwd_valid = fwd_src_valid &&
        fwd_src.rd_we &&
        (fwd_src.rd_addr != '0);

    assign fwd_rd_addr = fwd_src.rd_addr;

    assign fwd_data = fwd_src_valid ?
        fwd_src.result : '0;

endmodule
